exec_ctrl: RTL and testbench

- Execution sequencer for the 8-bit accumulator computer. It replaces the raw switch that currently clocks the PC and registers A/B.
- Debounces the step button and supports single-step and free-run modes. In free-run mode it produces a programmable-rate execution tick and halts on a PC breakpoint.
- step_en is a one-cycle clock enable that drives the PC and register A/B, all of which run on the board clock clk.

---
 rtl/exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_exec_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execution sequencer: debounced single-step and programmable-rate free-run
// with PC breakpoint halt, producing a one-cycle step enable for the datapath.
module exec_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int PC_W            = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sw,
    input  logic            mode,
    input  logic [PC_W-1:0] pc,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    output logic            step_en,
    output logic [1:0]      state,
    output logic            halted,
    output logic [15:0]     step_count
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    // Two-flop synchronisers: bit 0 = step button, bit 1 = mode switch.
    logic [1:0] raw_in;
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic       sw_s;
    logic       mode_s;

    assign raw_in = {mode, sw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= raw_in[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign sw_s   = sync_q[0];
    assign mode_s = sync_q[1];

    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             step_en_q, step_en_d;
    logic [15:0]      step_count_q, step_count_d;
    logic             tick;
    logic             bp_hit;

    // The level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (sw_s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            deb_d = sw_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = deb_d & ~deb_q;
    end

    assign tick   = (div_q == DIV_LAST);
    assign bp_hit = bp_en && (pc == bp_addr);

    // Same-cycle priority in RUN: breakpoint hit, then mode change, then tick.
    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        step_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode_s) begin
                    state_d = S_RUN;
                end else if (press_q) begin
                    step_en_d = 1'b1;
                end
            end
            S_RUN: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick && bp_hit) begin
                    state_d = S_HALT;
                    div_d   = '0;
                end else if (!mode_s) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (tick) begin
                    step_en_d = 1'b1;
                end
            end
            S_HALT: begin
                if (press_q) begin
                    step_en_d = 1'b1;
                    state_d   = mode_s ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign step_count_d = (step_en_q && step_count_q != 16'hFFFF) ?
                          step_count_q + 16'd1 : step_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            deb_q        <= 1'b0;
            press_q      <= 1'b0;
            state_q      <= S_IDLE;
            div_q        <= '0;
            step_en_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            deb_q        <= deb_d;
            press_q      <= press_d;
            state_q      <= state_d;
            div_q        <= div_d;
            step_en_q    <= step_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_en    = step_en_q;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign step_count = step_count_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed-vector bench for exec_ctrl with small debounce and run-rate settings.
module tb_exec_ctrl;

    logic        clk;
    logic        reset;
    logic        sw;
    logic        mode;
    logic [7:0]  pc_m;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic        step_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] step_count;

    exec_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (5),
        .PC_W           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .mode      (mode),
        .pc        (pc_m),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .step_en   (step_en),
        .state     (state),
        .halted    (halted),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model: advances on the edge that samples step_en.
    int pulse_cnt = 0;
    int consec    = 0;
    logic prev_en = 1'b0;
    always @(posedge clk) begin
        if (reset) pc_m <= 8'h00;
        else if (step_en) pc_m <= pc_m + 8'h01;
        if (step_en) pulse_cnt++;
        if (step_en && prev_en) consec++;
        prev_en = step_en;
    end

    typedef struct {
        logic        rst;
        logic        sw;
        logic        mode;
        logic        bp;
        int          cyc;
        logic [1:0]  st;
        logic        en;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic s, input logic m, input logic b,
                       input int c, input logic [1:0] st, input logic en,
                       input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.sw = s; v.mode = m; v.bp = b; v.cyc = c;
        v.st = st; v.en = en; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [1:0] st,
                                 input logic en, input logic [15:0] cnt);
        check("state", idx, {14'd0, state}, {14'd0, st});
        check("step_en", idx, {15'd0, step_en}, {15'd0, en});
        check("halted", idx, {15'd0, halted}, {15'd0, (st == 2'b10)});
        check("step_count", idx, step_count, cnt);
        $display("step %0d: state=%b step_en=%b halted=%b step_count=%h pc=%h",
                 idx, state, step_en, halted, step_count, pc_m);
    endtask

    int base_pulses;

    initial begin
        reset   = 1'b1;
        sw      = 1'b0;
        mode    = 1'b0;
        bp_en   = 1'b0;
        bp_addr = 8'h03;

        // Reset, then bounce that never stays stable long enough.
        add(1, 0, 0, 0, 3, 2'b00, 0, 16'd0);
        for (int i = 0; i < 10; i++) add(0, (i % 2 == 0), 0, 0, 2, 2'b00, 0, 16'd0);
        // Single step: pulse 7 edges after the sw change, held button gives one press.
        add(0, 1, 0, 0, 6,  2'b00, 0, 16'd0);
        add(0, 1, 0, 0, 1,  2'b00, 1, 16'd0);
        add(0, 1, 0, 0, 1,  2'b00, 0, 16'd1);
        add(0, 1, 0, 0, 50, 2'b00, 0, 16'd1);
        add(0, 0, 0, 0, 10, 2'b00, 0, 16'd1);
        // Run rate: RUN after 2 sync + 1, first pulse 5 cycles later, period 5.
        add(1, 0, 0, 0, 1,  2'b00, 0, 16'd0);
        add(0, 0, 1, 0, 2,  2'b00, 0, 16'd0);
        add(0, 0, 1, 0, 1,  2'b01, 0, 16'd0);
        add(0, 0, 1, 0, 4,  2'b01, 0, 16'd0);
        add(0, 0, 1, 0, 1,  2'b01, 1, 16'd0);
        add(0, 0, 1, 0, 1,  2'b01, 0, 16'd1);
        add(0, 0, 1, 0, 45, 2'b01, 0, 16'd10);
        // Breakpoint at pc 3: pulses at pc 0,1,2 then HALT.
        add(1, 0, 1, 1, 1,  2'b00, 0, 16'd0);
        add(0, 0, 1, 1, 3,  2'b01, 0, 16'd0);
        add(0, 0, 1, 1, 20, 2'b10, 0, 16'd3);
        add(0, 0, 1, 1, 10, 2'b10, 0, 16'd3);
        // Press steps past the breakpoint and resumes running.
        add(0, 1, 1, 1, 6,  2'b10, 0, 16'd3);
        add(0, 1, 1, 1, 1,  2'b01, 1, 16'd3);
        add(0, 1, 1, 1, 1,  2'b01, 0, 16'd4);
        add(0, 1, 1, 1, 4,  2'b01, 1, 16'd4);
        add(0, 1, 1, 1, 1,  2'b01, 0, 16'd5);
        // Mode drop early in the period: IDLE three edges later, no pulse.
        add(0, 0, 0, 1, 2,  2'b01, 0, 16'd5);
        add(0, 0, 0, 1, 1,  2'b00, 0, 16'd5);
        add(0, 0, 0, 1, 10, 2'b00, 0, 16'd5);
        add(0, 1, 0, 1, 6,  2'b00, 0, 16'd5);
        add(0, 1, 0, 1, 1,  2'b00, 1, 16'd5);
        add(0, 1, 0, 1, 1,  2'b00, 0, 16'd6);
        add(0, 0, 0, 1, 10, 2'b00, 0, 16'd6);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            sw    = vecs[i].sw;
            mode  = vecs[i].mode;
            bp_en = vecs[i].bp;
            repeat (vecs[i].cyc) @(negedge clk);
            check_outputs(i, vecs[i].st, vecs[i].en, vecs[i].cnt);
        end

        // Saturation: preload the counter near the top, then run.
        bp_en = 1'b0;
        force dut.step_count_q = 16'hFFFC;
        @(negedge clk);
        release dut.step_count_q;
        check("preload", 100, step_count, 16'hFFFC);
        base_pulses = pulse_cnt;
        mode = 1'b1;
        repeat (17) @(negedge clk);
        check("count_fffe", 101, step_count, 16'hFFFE);
        repeat (24) @(negedge clk);
        check("count_sat", 102, step_count, 16'hFFFF);
        check("pulses_at_sat", 102, 16'(pulse_cnt - base_pulses), 16'd7);
        $display("step 102: saturated step_count=%h pulses=%0d", step_count,
                 pulse_cnt - base_pulses);

        // Reset mid-RUN clears everything; RUN resumes without a stale tick.
        reset = 1'b1;
        @(negedge clk);
        check_outputs(103, 2'b00, 1'b0, 16'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs(104, 2'b01, 1'b0, 16'd0);
        mode = 1'b0;
        repeat (4) @(negedge clk);

        check("no_back_to_back", 105, 16'(consec), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
